// File: rtl/simon_kexp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_kexp_arbiter_if
// Brief    : Requester-side and expander-side signal bundle for the shared
//            SIMON key-expander arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface simon_kexp_arbiter_if #(
  parameter int SIMON_KEY_WIDTH = 128
);
  // Requester side
  logic [1:0]                   req_valid;
  logic [1:0]                   req_mode;
  logic [2*SIMON_KEY_WIDTH-1:0] req_key;
  logic [1:0]                   req_ready;
  logic [1:0]                   req_done;
  logic [1:0]                   req_err;
  logic                         owner;
  logic                         busy;
  // Expander side
  logic                         kx_mode;
  logic [SIMON_KEY_WIDTH-1:0]   kx_key;
  logic                         kx_valid;
  logic                         kx_ready;
  logic                         kx_exp_valid;
  logic                         kx_nrst;

  // Arbiter view
  modport slave (
    input  req_valid, req_mode, req_key, kx_ready, kx_exp_valid,
    output req_ready, req_done, req_err, owner, busy,
           kx_mode, kx_key, kx_valid, kx_nrst
  );

  // Environment view (requesters plus expander)
  modport master (
    output req_valid, req_mode, req_key, kx_ready, kx_exp_valid,
    input  req_ready, req_done, req_err, owner, busy,
           kx_mode, kx_key, kx_valid, kx_nrst
  );
endinterface
`default_nettype wire

// File: rtl/simon_kexp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simon_kexp_arbiter
// Brief    : Round-robin sharing of one SIMON key expander between two
//            requesters. Loads the expander, waits for exp_valid (with an
//            optional timeout), reports done/err to the owner and recycles
//            the expander through kx_nrst.
//            Optional feature macro: SIMON_KEY_CACHE_EN keeps the last
//            expanded {mode,key} live in the expander so an identical
//            request completes without reloading it.
// Revision : 1.0 - initial release
// ============================================================================
module simon_kexp_arbiter #(
  parameter int SIMON_KEY_WIDTH = 128,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  wire logic             ck,
  input  wire logic             rst,
  simon_kexp_arbiter_if.slave   bus
);

  localparam int          KW        = SIMON_KEY_WIDTH;
  localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RECYCLE = 3'd3,
    S_HIT     = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_last_grant;
  logic          r_owner;
  logic          r_kx_mode;
  logic [KW-1:0] r_kx_key;
  logic [1:0]    r_done;
  logic [1:0]    r_err;
  logic [15:0]   r_timer;
`ifdef SIMON_KEY_CACHE_EN
  logic          r_cache_valid;
  logic          r_reissue;
`endif

  logic          w_any;
  logic          w_grant;
  logic [KW-1:0] w_sel_key;
  logic          w_sel_mode;
  logic [15:0]   w_timer_inc;

  // Round-robin pick: a lone requester wins, on contention the one not served last
  assign w_any       = |bus.req_valid;
  assign w_grant     = (bus.req_valid == 2'b11) ? ~r_last_grant : bus.req_valid[1];
  assign w_sel_key   = w_grant ? bus.req_key[KW +: KW] : bus.req_key[0 +: KW];
  assign w_sel_mode  = bus.req_mode[w_grant];
  assign w_timer_inc = r_timer + 16'd1;

  assign bus.req_ready = (r_state == S_IDLE && !rst && w_any) ?
                         (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.req_done  = r_done;
  assign bus.req_err   = r_err;
  assign bus.owner     = r_owner;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.kx_mode   = r_kx_mode;
  assign bus.kx_key    = r_kx_key;
  assign bus.kx_valid  = (r_state == S_ISSUE);
  assign bus.kx_nrst   = ~rst & (r_state != S_RECYCLE);

  // Arbitration FSM: grant, load expander, wait for completion, recycle
  always_ff @(posedge ck) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_kx_mode    <= 1'b0;
      r_kx_key     <= '0;
      r_done       <= 2'b00;
      r_err        <= 2'b00;
      r_timer      <= 16'd0;
`ifdef SIMON_KEY_CACHE_EN
      r_cache_valid <= 1'b0;
      r_reissue     <= 1'b0;
`endif
    end else begin
      r_done <= 2'b00;
      r_err  <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_kx_key     <= w_sel_key;
            r_kx_mode    <= w_sel_mode;
`ifdef SIMON_KEY_CACHE_EN
            // Latched {mode,key} doubles as the cache tag while the expander holds DONE
            if (r_cache_valid && ({w_sel_mode, w_sel_key} == {r_kx_mode, r_kx_key})) begin
              r_done[w_grant] <= 1'b1;
              r_state         <= S_HIT;
            end else if (r_cache_valid) begin
              r_cache_valid <= 1'b0;
              r_reissue     <= 1'b1;
              r_state       <= S_RECYCLE;
            end else begin
              r_state <= S_ISSUE;
            end
`else
            r_state <= S_ISSUE;
`endif
          end
        end
        S_ISSUE: begin
          if (bus.kx_ready) begin
            r_timer <= 16'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_timer <= w_timer_inc;
          if (bus.kx_exp_valid) begin
            r_done[r_owner] <= 1'b1;
`ifdef SIMON_KEY_CACHE_EN
            r_cache_valid <= 1'b1;
            r_state       <= S_IDLE;
`else
            r_state <= S_RECYCLE;
`endif
          end else if (c_timeout != 16'd0 && w_timer_inc == c_timeout) begin
            r_err[r_owner] <= 1'b1;
            r_state        <= S_RECYCLE;
          end
        end
        S_RECYCLE: begin
`ifdef SIMON_KEY_CACHE_EN
          r_reissue <= 1'b0;
          r_state   <= r_reissue ? S_ISSUE : S_IDLE;
`else
          r_state <= S_IDLE;
`endif
        end
        S_HIT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_kexp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_kexp_arbiter
// Brief    : Self-checking bench for simon_kexp_arbiter: directed jobs then
//            randomized jobs against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_kexp_arbiter;

  localparam int KW = 128;
  localparam int T  = 16;

  logic ck;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [KW-1:0] key_q [2];
  logic          mode_q [2];
  logic [1:0]    pend;
  logic          last;

  simon_kexp_arbiter_if #(.SIMON_KEY_WIDTH(KW)) bus ();

  simon_kexp_arbiter #(
    .SIMON_KEY_WIDTH (KW),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_keys();
    bus.req_key  = {key_q[1], key_q[0]};
    bus.req_mode = {mode_q[1], mode_q[0]};
  endtask

  task automatic check_reset();
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    check("rst_req_done",  128'(bus.req_done),  128'(0));
    check("rst_req_err",   128'(bus.req_err),   128'(0));
    check("rst_owner",     128'(bus.owner),     128'(0));
    check("rst_busy",      128'(bus.busy),      128'(0));
    check("rst_kx_valid",  128'(bus.kx_valid),  128'(0));
    check("rst_kx_mode",   128'(bus.kx_mode),   128'(0));
    check("rst_kx_key",    bus.kx_key,          128'(0));
    check("rst_kx_nrst",   128'(bus.kx_nrst),   128'(0));
  endtask

  // One job: add = newly raised requests, lat = expander latency in WAIT
  // cycles (0 = never), rdy = cycles kx_ready stays low, abort_k = WAIT cycle
  // at which reset is applied (0 = none).
  task automatic run_job(input logic [1:0] add, input int lat, input int rdy, input int abort_k);
    logic [1:0] v;
    logic [1:0] newb;
    logic [1:0] oh;
    logic       g;
    logic       ng;
    bit         done_case;
    bit         ghost;
    int         endk;
    newb = add & ~pend;
    for (int b = 0; b < 2; b++) begin
      if (newb[b]) begin
        key_q[b]  = rand_key();
        mode_q[b] = 1'($urandom_range(0, 1));
      end
    end
    drive_keys();
    v  = pend | add;
    g  = (v == 2'b11) ? ~last : v[1];
    oh = 2'b01 << g;
    bus.req_valid = v;
    #1;
    check("req_ready", 128'(bus.req_ready), 128'(oh));
    check("idle_busy", 128'(bus.busy), 128'(0));
    last = g;
    pend = v & ~oh;
    @(negedge ck);
    bus.req_valid = pend;
    // Load phase: kx_valid held with a stable key until kx_ready
    for (int i = 0; i <= rdy; i++) begin
      check("kx_valid",    128'(bus.kx_valid), 128'(1));
      check("kx_key",      bus.kx_key, key_q[g]);
      check("kx_mode",     128'(bus.kx_mode), 128'(mode_q[g]));
      check("owner",       128'(bus.owner), 128'(g));
      check("issue_busy",  128'(bus.busy), 128'(1));
      check("issue_ready", 128'(bus.req_ready), 128'(0));
      check("issue_nrst",  128'(bus.kx_nrst), 128'(1));
      bus.kx_ready = (i == rdy);
      @(negedge ck);
    end
    bus.kx_ready = 1'b0;
    // Outcome: done one cycle after exp_valid, or err after T wait cycles
    done_case = (lat >= 1) && (lat <= T);
    endk      = done_case ? lat + 1 : T + 1;
    ng        = ~g;
    ghost     = !pend[ng] && (endk >= 4);
    for (int k = 1; k <= endk + 1; k++) begin
      check("req_done", 128'(bus.req_done), 128'((done_case && k == endk) ? oh : 2'b00));
      check("req_err",  128'(bus.req_err),  128'((!done_case && k == endk) ? oh : 2'b00));
      check("kx_nrst",  128'(bus.kx_nrst),  128'(k != endk));
      check("busy",     128'(bus.busy),     128'(k <= endk));
      check("wait_kx_valid", 128'(bus.kx_valid), 128'(0));
      if (k <= endk) check("wait_ready", 128'(bus.req_ready), 128'(0));
      if (k == endk + 1) break;
      if (abort_k != 0 && k == abort_k) begin
        rst              = 1'b1;
        bus.req_valid    = 2'b00;
        bus.kx_exp_valid = 1'b0;
        bus.kx_ready     = 1'b0;
        #1;
        check("abort_nrst", 128'(bus.kx_nrst), 128'(0));
        @(negedge ck);
        check_reset();
        @(negedge ck);
        check_reset();
        rst  = 1'b0;
        pend = 2'b00;
        last = 1'b1;
        return;
      end
      bus.kx_exp_valid = (lat >= 1) && (k >= lat) && (k < endk);
      bus.kx_ready     = 1'($urandom_range(0, 1));
      if (ghost && k == 2) bus.req_valid[ng] = 1'b1;
      if (ghost && k == 3) bus.req_valid[ng] = 1'b0;
      @(negedge ck);
    end
    bus.kx_exp_valid = 1'b0;
    bus.kx_ready     = 1'b0;
  endtask

  initial begin
    logic [1:0] add;
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    bus.req_valid    = 2'b11;
    bus.kx_ready     = 1'b0;
    bus.kx_exp_valid = 1'b0;
    key_q[0]  = 128'h0f0e0d0c0b0a09080706050403020100;
    mode_q[0] = 1'b1;
    key_q[1]  = rand_key();
    mode_q[1] = 1'b0;
    drive_keys();
    repeat (3) @(negedge ck);
    check_reset();
    rst  = 1'b0;
    pend = 2'b11;
    last = 1'b1;

    // Directed: req0 first after reset, then strict alternation under contention
    run_job(2'b00, 12, 0, 0);
    run_job(2'b01, 5, 1, 0);
    run_job(2'b10, 3, 2, 0);
    run_job(2'b00, 0, 0, 0);
    // Timeout on requester 0, then long kx_ready stall
    run_job(2'b01, 0, 0, 0);
    run_job(2'b10, 8, 10, 0);
    // Done and timeout landing in the same cycle
    run_job(2'b01, T, 0, 0);
    // Reset during WAIT, then a fresh request must still succeed
    run_job(2'b01, 14, 0, 5);
    run_job(2'b10, 4, 0, 0);

    for (int n = 0; n < 40; n++) begin
      add = 2'($urandom_range(0, 3));
      if ((pend | add) == 2'b00) add = 2'($urandom_range(1, 3));
      run_job(add, int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
